// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared encodings for the unified memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } arb_owner_e;

    // Access sizes use the RISC-V load/store funct3 encoding.
    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

endpackage

// File: rtl/unified_mem_arbiter_streak.sv
// arb_streak_ctr: counts consecutive data grants while a fetch waits and
// raises fetch priority once the streak reaches STREAK_MAX.
module arb_streak_ctr #(
    parameter int STREAK_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic if_pending,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic fetch_pri
);

    logic [3:0] streak_q, streak_d;

    assign fetch_pri = streak_q == 4'(STREAK_MAX);

    always_comb begin
        streak_d = (!if_pending || fetch_grant) ? 4'd0 :
                   (data_grant && !fetch_pri)   ? streak_q + 4'd1 : streak_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) streak_q <= 4'd0;
        else       streak_q <= streak_d;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: single-outstanding arbiter sharing one memory port between
// instruction fetch and load/store, data first with a bounded streak.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [2:0]        dm_size,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_size,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_accept,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              kill_q, kill_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_elig, dm_elig, idle, rsp;
    logic              grant_dm, grant_if, fetch_pri;

    // A requester whose done is visible is still holding the request it just finished.
    assign if_elig  = if_req & ~if_kill & ~if_done_q;
    assign dm_elig  = dm_req & ~dm_done_q;
    assign idle     = state_q == ST_IDLE;
    assign grant_dm = idle & dm_elig & ~(if_elig & fetch_pri);
    assign grant_if = idle & if_elig & ~grant_dm;
    assign rsp      = (state_q == ST_WAIT) & mem_rvalid;

    arb_streak_ctr #(
        .STREAK_MAX (STREAK_MAX)
    ) u_streak (
        .clock       (clock),
        .reset       (reset),
        .if_pending  (if_req),
        .data_grant  (grant_dm),
        .fetch_grant (grant_if),
        .fetch_pri   (fetch_pri)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_size_d  = mem_size_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        kill_d      = (idle | rsp) ? 1'b0 : kill_q | ((owner_q == OWN_FETCH) & if_kill);
        case (state_q)
            ST_IDLE: if (grant_dm | grant_if) begin
                state_d     = ST_ISSUE;
                owner_d     = grant_dm ? OWN_DATA : OWN_FETCH;
                mem_we_d    = grant_dm & dm_we;
                mem_addr_d  = grant_dm ? dm_addr : if_addr;
                mem_size_d  = grant_dm ? dm_size : SIZE_W;
                mem_wdata_d = grant_dm ? dm_wdata : '0;
            end
            ST_ISSUE: state_d = mem_accept ? ST_WAIT : ST_ISSUE;
            ST_WAIT: if (mem_rvalid) begin
                state_d    = ST_IDLE;
                owner_d    = OWN_NONE;
                dm_done_d  = owner_q == OWN_DATA;
                // A redirect seen on or before the response cycle makes it stale.
                if_done_d  = (owner_q == OWN_FETCH) & ~kill_q & ~if_kill;
                dm_rdata_d = dm_done_d ? mem_rdata : dm_rdata_q;
                if_rdata_d = if_done_d ? mem_rdata : if_rdata_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            kill_q      <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_size_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_size_q  <= mem_size_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_valid = state_q == ST_ISSUE;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_size  = mem_size_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_rdata_q;
    // Stalls are forced low during reset so every output reads 0 immediately.
    assign if_stall  = if_req & ~if_done_q & ~reset;
    assign dm_stall  = dm_req & ~dm_done_q & ~reset;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and randomized checks of the arbiter against a
// transaction-level model of who owns the memory and what it returns.
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    localparam int SMAX = 4;

    logic        clock = 1'b0, reset = 1'b1;
    logic        if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic        mem_accept = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [2:0]  dm_size = '0;
    logic        if_done, if_stall, dm_done, dm_stall, mem_valid, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    int          checks = 0, failures = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_size(dm_size),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_accept(mem_accept), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction view: one memory transaction is either absent, offered, or accepted.
    typedef struct {
        bit          busy, acc, kill, fetch, ifd, dmd;
        int          streak;
        logic        we;
        logic [31:0] addr, wdata, ifr, dmr;
        logic [2:0]  size;
    } mdl_t;

    mdl_t m = '{default: 0};

    function automatic mdl_t step_model(mdl_t s);
        mdl_t n = s;
        bit fe, de, gd, gf;
        n.ifd = 0;
        n.dmd = 0;
        fe = if_req && !if_kill && !s.ifd;
        de = dm_req && !s.dmd;
        gd = !s.busy && de && !(fe && s.streak == SMAX);
        gf = !s.busy && fe && !gd;
        if (gd || gf) begin
            n.busy = 1; n.acc = 0; n.kill = 0; n.fetch = gf;
            n.we = gd && dm_we;
            n.addr = gd ? dm_addr : if_addr;
            n.size = gd ? dm_size : SIZE_W;
            n.wdata = gd ? dm_wdata : 32'h0;
        end else if (s.busy && s.acc && mem_rvalid) begin
            n.busy = 0; n.kill = 0;
            if (!s.fetch) begin n.dmr = mem_rdata; n.dmd = 1; end
            else if (!s.kill && !if_kill) begin n.ifr = mem_rdata; n.ifd = 1; end
        end else if (s.busy) begin
            n.acc = s.acc || mem_accept;
            n.kill = s.kill || (s.fetch && if_kill);
        end
        n.streak = (!if_req || gf) ? 0 : gd ? ((s.streak + 1 > SMAX) ? SMAX : s.streak + 1) : s.streak;
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= '{default: 0};
        else       m <= step_model(m);
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("m_valid", mem_valid, m.busy && !m.acc);
            chk("m_we", mem_we, m.we);
            chk("m_addr", mem_addr, m.addr);
            chk("m_size", mem_size, m.size);
            chk("m_wdata", mem_wdata, m.wdata);
            chk("m_if_done", if_done, m.ifd);
            chk("m_if_rdata", if_rdata, m.ifr);
            chk("m_dm_done", dm_done, m.dmd);
            chk("m_dm_rdata", dm_rdata, m.dmr);
            chk("m_if_stall", if_stall, if_req && !m.ifd);
            chk("m_dm_stall", dm_stall, dm_req && !m.dmd);
        end
    end

    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int k);
        if_req = 0; if_kill = 0; dm_req = 0; mem_accept = 0; mem_rvalid = 0;
        repeat (k) nxt();
    endtask

    task automatic drain(input int k, input bit acc0);
        bit acc;
        acc = acc0;
        if_kill = 0;
        for (int i = 0; i < k; i++) begin
            if (if_done) if_req = 0;
            if (dm_done) dm_req = 0;
            mem_rvalid = acc; mem_accept = 1; acc = mem_valid;
            nxt();
        end
        mem_rvalid = 0; mem_accept = 0;
    endtask

    task automatic streak_run(input int n);
        bit acc;
        int dgrants;
        acc = 0; dgrants = 0;
        for (int c = 0; c <= 4 * n + 2; c++) begin
            if_req = 1; if_addr = 32'h0100_0300; if_kill = c < 4 * n;
            dm_req = 1; dm_we = 0; dm_size = SIZE_W; dm_addr = 32'h2000_0000 + n; dm_wdata = 0;
            mem_rvalid = acc; mem_accept = 1; mem_rdata = 32'h3000_0000 + c;
            #1;
            if (c < 4 * n && mem_valid) dgrants++;
            if (c == 4 * n + 1) begin
                chk("streak_valid", mem_valid, 1);
                chk("streak_owner_addr", mem_addr, n >= SMAX ? 32'h0100_0300 : 32'h2000_0000 + n);
            end
            acc = mem_valid;
            nxt();
        end
        chk("streak_data_grants", dgrants, n);
        drain(16, acc);
    endtask

    initial begin
        bit          acc, q;
        int          rt;
        logic [2:0]  sizes [5];
        sizes = '{SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU};
        repeat (3) @(negedge clock);
        #1;
        reset = 0;

        // Lone fetch: valid in cycle 1, done in cycle 3.
        for (int c = 0; c < 5; c++) begin
            if_req = c < 4; if_addr = 32'h0100_0000;
            mem_accept = c == 1; mem_rvalid = c == 2; mem_rdata = (c == 2) ? 32'h0000_0013 : 32'hFFFF_FFFF;
            #1;
            chk("t1_valid", mem_valid, c == 1);
            chk("t1_done", if_done, c == 3);
            chk("t1_stall", if_stall, c < 3);
            if (c == 1) chk("t1_addr", mem_addr, 32'h0100_0000);
            if (c == 3) chk("t1_rdata", if_rdata, 32'h0000_0013);
            nxt();
        end
        idle(2);

        // Redirect while waiting: stale response dropped, new fetch proceeds.
        for (int c = 0; c < 10; c++) begin
            if_req = c < 9; if_addr = (c < 2) ? 32'h0100_0010 : 32'h0100_0080; if_kill = c == 2;
            mem_accept = (c == 1) || (c == 6); mem_rvalid = (c == 4) || (c == 7);
            mem_rdata = (c == 4) ? 32'hBAD0_BAD0 : (c == 7) ? 32'h0050_0093 : 32'h0;
            #1;
            chk("t4_done", if_done, c == 8);
            if (c == 5) chk("t4_rdata_kept", if_rdata, 32'h0000_0013);
            if (c == 6) chk("t4_refetch_valid", mem_valid, 1);
            if (c == 6) chk("t4_refetch_addr", mem_addr, 32'h0100_0080);
            if (c == 8) chk("t4_rdata", if_rdata, 32'h0050_0093);
            nxt();
        end
        idle(2);

        // Contention: store first, fetch issued only after the store completes.
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if_req = c < 7; if_addr = 32'h0100_0200;
            dm_req = c < 4; dm_we = 1; dm_addr = 32'h0100_0100; dm_wdata = 32'hDEAD_BEEF; dm_size = SIZE_W;
            mem_rvalid = acc; mem_accept = 1; mem_rdata = 32'h1111_0000 + c;
            #1;
            chk("t2_valid", mem_valid, (c == 1) || (c == 4));
            chk("t2_dm_done", dm_done, c == 3);
            chk("t2_if_done", if_done, c == 6);
            if (c == 1) begin
                chk("t2_st_we", mem_we, 1);
                chk("t2_st_addr", mem_addr, 32'h0100_0100);
                chk("t2_st_wdata", mem_wdata, 32'hDEAD_BEEF);
                chk("t2_st_size", mem_size, 3'b010);
            end
            if (c == 4) begin
                chk("t2_if_we", mem_we, 0);
                chk("t2_if_addr", mem_addr, 32'h0100_0200);
            end
            if (c == 6) chk("t2_if_rdata", if_rdata, 32'h1111_0005);
            acc = mem_valid;
            nxt();
        end
        drain(8, acc);
        idle(2);

        streak_run(3);
        idle(2);
        streak_run(SMAX);
        idle(2);
        streak_run(6);
        idle(2);

        // Backpressure: request fields frozen while not accepted.
        for (int c = 0; c < 10; c++) begin
            dm_req = c < 9; dm_we = 1; dm_addr = 32'h0300_0040; dm_size = SIZE_H; dm_wdata = 32'h0000_BEEF;
            mem_accept = c == 6; mem_rvalid = c == 7; mem_rdata = 32'h0000_5555;
            #1;
            if (c >= 1 && c <= 6) begin
                chk("t5_valid", mem_valid, 1);
                chk("t5_addr", mem_addr, 32'h0300_0040);
                chk("t5_we", mem_we, 1);
                chk("t5_size", mem_size, 3'b001);
                chk("t5_wdata", mem_wdata, 32'h0000_BEEF);
            end
            chk("t5_done", dm_done, c == 8);
            chk("t5_stall", dm_stall, c < 8);
            nxt();
        end
        idle(2);

        // Randomized traffic, quiescing at the end so nothing is left in flight.
        rt = 0;
        for (int i = 0; i < 4000; i++) begin
            q = i >= 3960;
            mem_rvalid = rt == 1;
            if (rt > 0) rt--;
            if (!q && rt == 0 && !mem_valid && ($urandom % 20) == 0) mem_rvalid = 1;
            mem_rdata = $urandom;
            mem_accept = ($urandom % 3) != 0;
            if (mem_valid && mem_accept) rt = 1 + int'($urandom % 3);
            if_kill = !q && ($urandom % 12) == 0;
            if (!if_req) begin
                if (!q && ($urandom % 3) == 0) begin if_req = 1; if_addr = $urandom; end
            end else if (if_done || if_kill) begin
                if_req = !q && ($urandom % 4) != 0; if_addr = $urandom;
            end
            if (!dm_req) begin
                if (!q && ($urandom % 3) == 0) begin
                    dm_req = 1; dm_we = $urandom % 2; dm_addr = $urandom;
                    dm_size = sizes[$urandom % 5]; dm_wdata = $urandom;
                end
            end else if (dm_done) begin
                dm_req = !q && ($urandom % 3) != 0; dm_we = $urandom % 2; dm_addr = $urandom;
                dm_size = sizes[$urandom % 5]; dm_wdata = $urandom;
            end
            nxt();
        end
        idle(3);

        // Async reset while waiting for a response, then a stray response.
        for (int c = 0; c < 2; c++) begin
            if_req = 1; if_addr = 32'h0100_0400; mem_accept = c == 1; mem_rvalid = 0;
            nxt();
        end
        mem_accept = 0;
        chk("t6_pre_stall", if_stall, 1);
        reset = 1;
        #1;
        chk("t6_valid", mem_valid, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_size", mem_size, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_if_done", if_done, 0);
        chk("t6_if_rdata", if_rdata, 0);
        chk("t6_if_stall", if_stall, 0);
        chk("t6_dm_done", dm_done, 0);
        chk("t6_dm_rdata", dm_rdata, 0);
        chk("t6_dm_stall", dm_stall, 0);
        nxt();
        reset = 0; if_req = 0;
        nxt();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        nxt();
        mem_rvalid = 0;
        for (int c = 0; c < 2; c++) begin
            chk("t6_stray_if_done", if_done, 0);
            chk("t6_stray_dm_done", dm_done, 0);
            chk("t6_stray_valid", mem_valid, 0);
            nxt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (load/store) of the 5-stage core.
- Only one transaction is outstanding at a time.
- Data-side requests have priority, with a bounded streak so fetch is never starved.
- Per-requester stall outputs feed pipeline_control.
- A fetch-kill input discards responses made stale by a taken branch or jump.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STREAK_MAX, 4, maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_done or if_kill.
- if_addr  in  ADDR_W  fetch address (pc_f).
- if_kill  in  1  pipeline redirect; abandons the current fetch request or response.
- if_done  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req & ~if_done.
- dm_req  in  1  data request; held with all dm_* fields until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address (alu_out_m).
- dm_size  in  3  access size, funct3 encoding.
- dm_wdata  in  DATA_W  store data.
- dm_done  out  1  one-cycle completion pulse (loads and stores).
- dm_rdata  out  DATA_W  load data.
- dm_stall  out  1  dm_req & ~dm_done.
- mem_valid  out  1  request valid to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_size  out  3  access size to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_accept  in  1  memory takes the request this cycle (valid & accept).
- mem_rvalid  in  1  response or write-acknowledge, one cycle, exactly one per accepted request.
- mem_rdata  in  DATA_W  read data, qualified by mem_rvalid.

Behaviour:
- Reset values: all outputs 0, state IDLE, owner NONE, streak 0, kill_pending 0.
- Reset asserted mid-transaction aborts it. A later mem_rvalid with state IDLE is ignored.

FSM states:
- IDLE, ISSUE (mem_valid=1), WAIT (awaiting mem_rvalid).
- IDLE to ISSUE when an eligible request exists.
  - The winner's fields are registered into mem_*.
  - mem_valid rises the cycle after the request is sampled.
- ISSUE to WAIT on mem_accept. mem_valid drops and the mem_* fields stay stable while mem_valid=1.
- WAIT to IDLE on mem_rvalid.
  - mem_rdata is registered into the owner's rdata.
  - The owner's done pulses the next cycle.
- Minimum latency, request to done, is 3 cycles: accept in the first ISSUE cycle, rvalid the cycle after.

Eligibility and arbitration:
- A requester whose done is high this cycle is ineligible. This prevents a re-grant of a request that is still held while its done is visible.
- if_req is ineligible while if_kill=1.
- Both eligible: data wins unless streak == STREAK_MAX, in which case fetch wins.
- streak increments on a data grant while if_req is pending, saturating at STREAK_MAX.
- streak clears on a fetch grant, or on any cycle with if_req=0.

Kill:
- if_kill while owner=FETCH in ISSUE or WAIT sets kill_pending.
  - mem_valid is never withdrawn.
  - On the rvalid, if_done is suppressed and if_rdata is unchanged.
- kill_pending clears on return to IDLE.
- if_kill with no fetch in flight has no effect.
- if_kill has no effect on data transactions.

Simultaneous events:
- mem_rvalid and if_kill in the same cycle: the response is dropped.
- dm_req and if_req arriving in the same cycle while busy: both wait, and arbitration happens in IDLE.
- The arbiter never issues two transactions back-to-back without an IDLE cycle.

Decomposition:
- Shared constants header/package:
  - state encodings IDLE/ISSUE/WAIT;
  - owner encodings NONE/FETCH/DATA;
  - access-size codes (SIZE_B/H/W/BU/HU, matching funct3).
- One sub-module, arb_streak_ctr: saturating streak counter plus fetch-priority flag, parameterised by STREAK_MAX.

Test Plan:
- Fetch only: if_req=1, if_addr=0x01000000, accept immediate, rvalid next cycle with rdata=0x00000013 -> mem_valid at cycle 1, if_done at cycle 3, if_rdata=0x00000013, if_stall high cycles 0-2.
- Contention: if_req and dm_req (store, addr 0x01000100, wdata 0xDEADBEEF, size 3'b010) raised together -> data is issued first with mem_we=1, dm_done pulses, then fetch is issued; no cycle has mem_valid for two owners.
- Starvation bound, STREAK_MAX=4: dm_req re-raised every cycle after done, if_req held -> exactly 4 data grants, then the 5th grant is fetch.
- Kill in WAIT: fetch accepted, if_kill pulsed 1 cycle, rvalid 2 cycles later -> no if_done, if_rdata unchanged, next fetch issued normally.
- Memory backpressure: mem_accept held 0 for 5 cycles -> mem_valid and mem_addr/mem_we/mem_size/mem_wdata stable all 5 cycles; done 2 cycles after accept.
- Async reset while in WAIT -> all outputs 0 immediately (before the next edge); a stray mem_rvalid afterward produces no done.
